// File: rtl/_arbmuxwfromn_pkg.sv
// Shared arbitration definitions: mode constants and the pointer-width helper
// used by every arbiter in the bus fabric.
package _arbmuxwfromn_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Pointer needs at least one bit even when there is a single source.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/_arbmuxwfromn_rr_pick.sv
// Combinational rotate-and-priority-encode picker: finds the first requester
// after ptr (round-robin) or the lowest requester (fixed priority).
module _rr_pick
  import _arbmuxwfromn_pkg::*;
#(
  parameter int N = 8,
  localparam int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  arb_mode_e     mode,
  output logic [N-1:0]  sel_oh,
  output logic [PW-1:0] sel
);

  localparam int SW = PW + 1;
  localparam logic [SW-1:0] N_W = SW'(N);

  logic [PW-1:0]  start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic           found;
  logic [SW-1:0]  off;
  logic [SW-1:0]  idx;

  // Rotate the request vector so the search origin sits at bit 0, encode the
  // lowest set bit, then rotate the result back into source numbering.
  always_comb begin
    start = '0;
    if (mode == ARB_RR && N > 1) begin
      start = (ptr == PW'(N - 1)) ? '0 : ptr + PW'(1);
    end
    dbl   = {req, req};
    rot   = dbl[start +: N];
    found = 1'b0;
    off   = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = SW'(j);
      end
    end
    idx = {1'b0, start} + off;
    if (idx >= N_W) begin
      idx = idx - N_W;
    end
    sel    = idx[PW-1:0];
    sel_oh = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/_arbmuxwfromn.sv
// Registered N-to-1 bus arbiter/mux with req/ack sources, a valid/ready
// consumer port and active-low one-hot owner enables for 74x244 drivers.
module _arbmuxwfromn
  import _arbmuxwfromn_pkg::*;
#(
  parameter int W    = 32,
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [W*N-1:0] a,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   y,
  output logic           valid,
  input  logic           ready,
  output logic [N-1:0]   owner_n
);

  localparam int PW = ptr_width(N);
  localparam arb_mode_e ARB_MODE = (MODE == 1) ? ARB_FIXED : ARB_RR;

  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [N-1:0]  sel_oh;
  logic          load;
  logic          any_req;
  logic [W-1:0]  y_next;

  assign load    = !valid || ready;
  assign any_req = |req;

  _rr_pick #(.N(N)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .mode   (ARB_MODE),
    .sel_oh (sel_oh),
    .sel    (sel)
  );

  // A grant is only offered when the output register can actually take it.
  assign ack = (rst_n && load) ? sel_oh : '0;

  always_comb begin
    y_next = '0;
    for (int i = 0; i < N; i++) begin
      y_next = y_next | (a[i*W +: W] & {W{sel_oh[i]}});
    end
  end

  // Reset parks ptr on the last source so the first round-robin pick is 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      y       <= '0;
      owner_n <= '1;
      ptr     <= PW'(N - 1);
    end else if (load) begin
      if (any_req) begin
        y       <= y_next;
        valid   <= 1'b1;
        owner_n <= ~sel_oh;
        ptr     <= sel;
      end else begin
        valid   <= 1'b0;
        owner_n <= '1;
      end
    end
  end

endmodule

// File: tb/tb__arbmuxwfromn.sv
// Bench for _arbmuxwfromn: a round-robin and a fixed-priority instance share
// stimulus and are checked every cycle against a behavioural model.
module tb__arbmuxwfromn;

  localparam int W = 32;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [W*N-1:0] a;
  logic         ready;

  logic [N-1:0] ack_rr, ack_fp, owner_n_rr, owner_n_fp;
  logic [W-1:0] y_rr, y_fp;
  logic         valid_rr, valid_fp;

  int errors = 0;
  int checks = 0;

  logic        m_valid [2];
  logic [31:0] m_y     [2];
  int          m_owner [2];
  int          m_ptr   [2];
  bit          m_init = 1'b0;

  always #5 clk = ~clk;

  _arbmuxwfromn #(.W(W), .N(N), .MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .ack(ack_rr),
    .y(y_rr), .valid(valid_rr), .ready(ready), .owner_n(owner_n_rr)
  );

  _arbmuxwfromn #(.W(W), .N(N), .MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .ack(ack_fp),
    .y(y_fp), .valid(valid_fp), .ready(ready), .owner_n(owner_n_fp)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [N-1:0] rq, input logic rd);
    @(posedge clk);
    #1;
    rst_n = r;
    req   = rq;
    ready = rd;
  endtask

  // Model: index of the source the arbiter must grant this cycle, or -1.
  function automatic int exp_sel(input int d);
    int i;
    if (!rst_n) return -1;
    if (m_valid[d] && !ready) return -1;
    for (int k = 1; k <= N; k++) begin
      i = (d == 1) ? (k - 1) : ((m_ptr[d] + k) % N);
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_ack(input int d);
    int s;
    s = exp_sel(d);
    return (s < 0) ? 8'h00 : (8'h01 << s);
  endfunction

  function automatic logic [7:0] exp_owner_n(input int d);
    return (m_owner[d] < 0) ? 8'hFF : (8'hFF ^ (8'h01 << m_owner[d]));
  endfunction

  always @(posedge clk) begin
    int s [2];
    for (int d = 0; d < 2; d++) s[d] = exp_sel(d);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_valid[d] = 1'b0;
        m_y[d]     = 32'h0;
        m_owner[d] = -1;
        m_ptr[d]   = N - 1;
      end else if (!m_valid[d] || ready) begin
        if (s[d] >= 0) begin
          m_valid[d] = 1'b1;
          m_y[d]     = a[s[d]*W +: W];
          m_owner[d] = s[d];
          m_ptr[d]   = s[d];
        end else begin
          m_valid[d] = 1'b0;
          m_owner[d] = -1;
        end
      end
    end
    if (!rst_n) m_init = 1'b1;
  end

  always @(negedge clk) begin
    if (m_init) begin
      checkOutput("rr_y",       y_rr,       m_y[0]);
      checkOutput("rr_valid",   valid_rr,   m_valid[0]);
      checkOutput("rr_owner_n", owner_n_rr, exp_owner_n(0));
      checkOutput("rr_ack",     ack_rr,     exp_ack(0));
      checkOutput("fp_y",       y_fp,       m_y[1]);
      checkOutput("fp_valid",   valid_fp,   m_valid[1]);
      checkOutput("fp_owner_n", owner_n_fp, exp_owner_n(1));
      checkOutput("fp_ack",     ack_fp,     exp_ack(1));
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    ready = 1'b1;
    for (int i = 0; i < N; i++) a[i*W +: W] = 32'hA000_0000 + i;

    // Reset held with every source requesting.
    repeat (2) begin
      @(negedge clk);
      checkOutput("lit_reset_ack_rr", ack_rr, 8'h00);
      checkOutput("lit_reset_ack_fp", ack_fp, 8'h00);
      checkOutput("lit_reset_valid",  valid_rr, 1'b0);
      checkOutput("lit_reset_y",      y_rr, 32'h0);
      checkOutput("lit_reset_own",    owner_n_rr, 8'hFF);
    end
    applyStimulus(1'b1, 8'hFF, 1'b1);

    // Round-robin sweep with a wrap back to source 0.
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      checkOutput("lit_rr_ack", ack_rr, 8'h01 << (k % 8));
      checkOutput("lit_fp_ack", ack_fp, 8'h01);
      if (k > 0) begin
        checkOutput("lit_rr_y",   y_rr, 32'hA000_0000 + (k - 1));
        checkOutput("lit_rr_own", owner_n_rr, 8'hFF ^ (8'h01 << (k - 1)));
      end
    end

    // Backpressure: the held word must not move and no grant is offered.
    applyStimulus(1'b1, 8'h0C, 1'b0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("lit_bp_ack", ack_rr, 8'h00);
      checkOutput("lit_bp_y",   y_rr, 32'hA000_0000);
      checkOutput("lit_bp_own", owner_n_rr, 8'hFE);
    end
    applyStimulus(1'b1, 8'h0C, 1'b1);
    @(negedge clk);
    checkOutput("lit_bp_rel_ack_rr", ack_rr, 8'h04);
    checkOutput("lit_bp_rel_ack_fp", ack_fp, 8'h04);

    // Move ptr to 6, then wrap 6 -> 7 -> 0, then drain.
    applyStimulus(1'b1, 8'h40, 1'b1);
    @(negedge clk);
    checkOutput("lit_bp_y_next", y_rr, 32'hA000_0002);
    checkOutput("lit_p6_ack",    ack_rr, 8'h40);
    applyStimulus(1'b1, 8'h41, 1'b1);
    @(negedge clk);
    checkOutput("lit_wrap_ack_rr", ack_rr, 8'h01);
    checkOutput("lit_wrap_ack_fp", ack_fp, 8'h01);
    applyStimulus(1'b1, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("lit_wrap_y",    y_rr, 32'hA000_0000);
    checkOutput("lit_drain_ack", ack_rr, 8'h00);
    applyStimulus(1'b1, 8'h00, 1'b1);
    @(negedge clk);
    checkOutput("lit_drain_valid", valid_rr, 1'b0);
    checkOutput("lit_drain_own",   owner_n_rr, 8'hFF);
    checkOutput("lit_drain_y",     y_rr, 32'hA000_0000);

    // Fixed priority: source 4 always beats source 7.
    applyStimulus(1'b1, 8'h90, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("lit_fp_prio_ack", ack_fp, 8'h10);
      if (k > 0) begin
        checkOutput("lit_fp_prio_y",   y_fp, 32'hA000_0004);
        checkOutput("lit_fp_prio_own", owner_n_fp, 8'hEF);
      end
    end

    // Reset while a word is held under backpressure.
    applyStimulus(1'b1, 8'h01, 1'b1);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    @(negedge clk);
    checkOutput("lit_mid_valid_pre", valid_rr, 1'b1);
    applyStimulus(1'b0, 8'hFF, 1'b0);
    @(negedge clk);
    checkOutput("lit_mid_ack_rr", ack_rr, 8'h00);
    checkOutput("lit_mid_ack_fp", ack_fp, 8'h00);
    applyStimulus(1'b1, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("lit_mid_valid", valid_rr, 1'b0);
    checkOutput("lit_mid_y",     y_rr, 32'h0);
    checkOutput("lit_mid_own",   owner_n_rr, 8'hFF);
    checkOutput("lit_mid_valid_fp", valid_fp, 1'b0);

    // Randomised traffic with occasional resets; the model checks each cycle.
    repeat (600) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom & $urandom);
      applyStimulus($urandom_range(0, 39) != 0, r, $urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) a[i*W +: W] = $urandom;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
